alu_share_ctrl: RTL and testbench

- Shares the single registered execute ALU between two requesters: requester 0 is the pipeline execute stage; requester 1 is the branch/address unit.
- Arbitrates requests round-robin and latches the winner's operands, op and pc.
- Holds the ALU inputs stable for the ALU's registered latency, captures data_out/zero and returns them with a one-cycle response pulse.
- Sits between the ID/EX stage registers and the alu instance.

---
 rtl/alu_share_pkg.sv | 50 +++++
 rtl/alu_share_ctrl_rr_arb2.sv | 34 +++
 rtl/alu_share_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_pkg
// Description : Shared types and constants for the execute-ALU sharing
//               controller. Holds the opcode map, the controller state
//               encoding and the default bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_share_pkg;

    // Default bus widths
    localparam int DATA_W_DEF = 32;
    localparam int OP_W_DEF   = 6;
    localparam int PC_W_DEF   = 6;

    // ALU opcode map
    localparam logic [5:0] ALU_OP_ADD   = 6'd0;
    localparam logic [5:0] ALU_OP_SUB   = 6'd1;
    localparam logic [5:0] ALU_OP_AND   = 6'd2;
    localparam logic [5:0] ALU_OP_OR    = 6'd3;
    localparam logic [5:0] ALU_OP_XOR   = 6'd4;
    localparam logic [5:0] ALU_OP_SLL   = 6'd5;
    localparam logic [5:0] ALU_OP_SRL   = 6'd6;
    localparam logic [5:0] ALU_OP_SRA   = 6'd7;
    localparam logic [5:0] ALU_OP_SLT   = 6'd8;
    localparam logic [5:0] ALU_OP_SLTU  = 6'd9;
    localparam logic [5:0] ALU_OP_BEQ   = 6'd10;
    localparam logic [5:0] ALU_OP_BNE   = 6'd11;
    localparam logic [5:0] ALU_OP_BLT   = 6'd12;
    localparam logic [5:0] ALU_OP_BGE   = 6'd13;
    localparam logic [5:0] ALU_OP_BLTU  = 6'd14;
    localparam logic [5:0] ALU_OP_BGEU  = 6'd15;
    localparam logic [5:0] ALU_OP_LUI   = 6'd16;
    localparam logic [5:0] ALU_OP_JAL   = 6'd17;
    localparam logic [5:0] ALU_OP_JALR  = 6'd18;
    localparam logic [5:0] ALU_OP_AUIPC = 6'd19;

    // Highest legal opcode; anything above is answered with an error
    localparam int LAST_OP = 19;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_share_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin picker. A sole requester wins outright;
//               when both request, the pointer chooses. The next pointer
//               favours the requester that did not win.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       req_0_i,
    input  logic       req_1_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o,
    output logic       ptr_next_o
);

    // One-hot winner selection and pointer advance
    always_comb begin
        gnt_o      = 2'b00;
        ptr_next_o = ptr_i;
        if (req_0_i && req_1_i) begin
            gnt_o = ptr_i ? 2'b10 : 2'b01;
        end else begin
            gnt_o = {req_1_i, req_0_i};
        end
        if (gnt_o[0]) begin
            ptr_next_o = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_next_o = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_ctrl
// Description : Shares one registered execute ALU between the pipeline
//               execute stage (requester 0) and the branch/address unit
//               (requester 1). Round-robin arbitration, operand latching,
//               latency wait and one-cycle response pulse to the owner.
//               Optional macro ALU_SHARE_PERF_EN adds saturating grant and
//               stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int OP_W        = OP_W_DEF,
    parameter int PC_W        = PC_W_DEF,
    parameter int ALU_LATENCY = 1,
    parameter int LAST_OP     = alu_share_pkg::LAST_OP
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_0,
    input  logic              req_1,
    input  logic [OP_W-1:0]   op_0,
    input  logic [OP_W-1:0]   op_1,
    input  logic [DATA_W-1:0] a_0,
    input  logic [DATA_W-1:0] a_1,
    input  logic [DATA_W-1:0] b_0,
    input  logic [DATA_W-1:0] b_1,
    input  logic [PC_W-1:0]   pc_0,
    input  logic [PC_W-1:0]   pc_1,
    output logic              gnt_0,
    output logic              gnt_1,
    output logic              rsp_valid_0,
    output logic              rsp_valid_1,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic              busy,
    output logic [DATA_W-1:0] alu_data_1,
    output logic [DATA_W-1:0] alu_data_2,
    output logic [OP_W-1:0]   alu_op,
    output logic [PC_W-1:0]   alu_pc,
    input  logic [DATA_W-1:0] alu_data_out,
    input  logic              alu_zero
`ifdef ALU_SHARE_PERF_EN
    ,
    output logic [15:0]       gnt_cnt_0,
    output logic [15:0]       gnt_cnt_1,
    output logic [15:0]       stall_cnt
`endif
);

    // Latency counter is sized for the full legal range 1..4
    localparam int                CNT_W     = 3;
    localparam logic [CNT_W-1:0]  LAT_C     = CNT_W'(ALU_LATENCY);
    localparam logic [OP_W-1:0]   LAST_OP_C = OP_W'(LAST_OP);
    localparam logic [OP_W-1:0]   OP_IDLE_C = OP_W'(ALU_OP_ADD);

    state_e              state_q;
    logic                ptr_q;
    logic                ptr_d;
    logic                owner_q;
    logic                err_pend_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [PC_W-1:0]     pc_q;
    logic                gnt_0_q;
    logic                gnt_1_q;
    logic                rsp_valid_0_q;
    logic                rsp_valid_1_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_zero_q;
    logic                rsp_err_q;
    logic                busy_q;

    logic [1:0]          arb_gnt;
    logic [OP_W-1:0]     sel_op;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [PC_W-1:0]     sel_pc;
    logic                sel_illegal;

    rr_arb2 u_arb (
        .req_0_i    (req_0),
        .req_1_i    (req_1),
        .ptr_i      (ptr_q),
        .gnt_o      (arb_gnt),
        .ptr_next_o (ptr_d)
    );

    // Winner's request fields; only meaningful when arb_gnt is non-zero
    assign sel_op      = arb_gnt[1] ? op_1 : op_0;
    assign sel_a       = arb_gnt[1] ? a_1  : a_0;
    assign sel_b       = arb_gnt[1] ? b_1  : b_0;
    assign sel_pc      = arb_gnt[1] ? pc_1 : pc_0;
    assign sel_illegal = (sel_op > LAST_OP_C);

    // Controller FSM with latency counter, operand and response registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= 1'b0;
            owner_q       <= 1'b0;
            err_pend_q    <= 1'b0;
            cnt_q         <= '0;
            op_q          <= OP_IDLE_C;
            a_q           <= '0;
            b_q           <= '0;
            pc_q          <= '0;
            gnt_0_q       <= 1'b0;
            gnt_1_q       <= 1'b0;
            rsp_valid_0_q <= 1'b0;
            rsp_valid_1_q <= 1'b0;
            rsp_data_q    <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_err_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            gnt_0_q       <= 1'b0;
            gnt_1_q       <= 1'b0;
            rsp_valid_0_q <= 1'b0;
            rsp_valid_1_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|arb_gnt) begin
                        gnt_0_q    <= arb_gnt[0];
                        gnt_1_q    <= arb_gnt[1];
                        owner_q    <= arb_gnt[1];
                        ptr_q      <= ptr_d;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ISSUE;
                        err_pend_q <= sel_illegal;
                        // An illegal op never reaches the ALU inputs
                        if (!sel_illegal) begin
                            op_q <= sel_op;
                            a_q  <= sel_a;
                            b_q  <= sel_b;
                            pc_q <= sel_pc;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (err_pend_q) begin
                        // Answer the illegal op straight away
                        err_pend_q    <= 1'b0;
                        rsp_data_q    <= '0;
                        rsp_zero_q    <= 1'b0;
                        rsp_err_q     <= 1'b1;
                        rsp_valid_0_q <= ~owner_q;
                        rsp_valid_1_q <= owner_q;
                        state_q       <= ST_RESP;
                    end else begin
                        cnt_q   <= LAT_C;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_data_q    <= alu_data_out;
                        rsp_zero_q    <= alu_zero;
                        rsp_err_q     <= 1'b0;
                        rsp_valid_0_q <= ~owner_q;
                        rsp_valid_1_q <= owner_q;
                        op_q          <= OP_IDLE_C;
                        a_q           <= '0;
                        b_q           <= '0;
                        pc_q          <= '0;
                        state_q       <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    op_q    <= OP_IDLE_C;
                    a_q     <= '0;
                    b_q     <= '0;
                    pc_q    <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_0       = gnt_0_q;
    assign gnt_1       = gnt_1_q;
    assign rsp_valid_0 = rsp_valid_0_q;
    assign rsp_valid_1 = rsp_valid_1_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = busy_q;
    assign alu_data_1  = a_q;
    assign alu_data_2  = b_q;
    assign alu_op      = op_q;
    assign alu_pc      = pc_q;

`ifdef ALU_SHARE_PERF_EN
    logic [15:0] gnt_cnt_0_q;
    logic [15:0] gnt_cnt_1_q;
    logic [15:0] stall_cnt_q;
    logic        stall_w;

    // A stall cycle: someone is asking but nobody is being accepted
    assign stall_w = (req_0 | req_1) & ~(gnt_0_q | gnt_1_q);

    // Saturating grant and stall counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt_cnt_0_q <= '0;
            gnt_cnt_1_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (gnt_0_q && (gnt_cnt_0_q != 16'hFFFF)) begin
                gnt_cnt_0_q <= gnt_cnt_0_q + 16'd1;
            end
            if (gnt_1_q && (gnt_cnt_1_q != 16'hFFFF)) begin
                gnt_cnt_1_q <= gnt_cnt_1_q + 16'd1;
            end
            if (stall_w && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign gnt_cnt_0 = gnt_cnt_0_q;
    assign gnt_cnt_1 = gnt_cnt_1_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_ctrl
// Description : Scoreboard bench for alu_share_ctrl. One instance with
//               ALU_LATENCY=1 and one with ALU_LATENCY=3, each driving a
//               small behavioural ALU model of matching depth.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- main instance (ALU_LATENCY = 1) ----------------
    logic        reset;
    logic        req_0, req_1;
    logic [5:0]  op_0, op_1, pc_0, pc_1;
    logic [31:0] a_0, a_1, b_0, b_1;
    logic        gnt_0, gnt_1, rsp_valid_0, rsp_valid_1, rsp_zero, rsp_err, busy;
    logic [31:0] rsp_data, alu_data_1, alu_data_2, alu_data_out;
    logic [5:0]  alu_op, alu_pc;
    logic        alu_zero;
`ifdef ALU_SHARE_PERF_EN
    logic [15:0] gnt_cnt_0, gnt_cnt_1, stall_cnt;
    logic [15:0] d3_gnt_cnt_0, d3_gnt_cnt_1, d3_stall_cnt;
`endif

    // ---------------- second instance (ALU_LATENCY = 3) ----------------
    logic        reset3;
    logic        d3_req_0, d3_req_1;
    logic [5:0]  d3_op_0, d3_op_1, d3_pc_0, d3_pc_1;
    logic [31:0] d3_a_0, d3_a_1, d3_b_0, d3_b_1;
    logic        d3_gnt_0, d3_gnt_1, d3_rsp_valid_0, d3_rsp_valid_1;
    logic        d3_rsp_zero, d3_rsp_err, d3_busy;
    logic [31:0] d3_rsp_data, d3_alu_data_1, d3_alu_data_2, d3_alu_data_out;
    logic [5:0]  d3_alu_op, d3_alu_pc;
    logic        d3_alu_zero;

    alu_share_ctrl #(.DATA_W(32), .OP_W(6), .PC_W(6), .ALU_LATENCY(1), .LAST_OP(19)) u_dut (
        .clock(clock), .reset(reset),
        .req_0(req_0), .req_1(req_1), .op_0(op_0), .op_1(op_1),
        .a_0(a_0), .a_1(a_1), .b_0(b_0), .b_1(b_1), .pc_0(pc_0), .pc_1(pc_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy),
        .alu_data_1(alu_data_1), .alu_data_2(alu_data_2), .alu_op(alu_op), .alu_pc(alu_pc),
        .alu_data_out(alu_data_out), .alu_zero(alu_zero)
`ifdef ALU_SHARE_PERF_EN
        , .gnt_cnt_0(gnt_cnt_0), .gnt_cnt_1(gnt_cnt_1), .stall_cnt(stall_cnt)
`endif
    );

    alu_share_ctrl #(.DATA_W(32), .OP_W(6), .PC_W(6), .ALU_LATENCY(3), .LAST_OP(19)) u_dut3 (
        .clock(clock), .reset(reset3),
        .req_0(d3_req_0), .req_1(d3_req_1), .op_0(d3_op_0), .op_1(d3_op_1),
        .a_0(d3_a_0), .a_1(d3_a_1), .b_0(d3_b_0), .b_1(d3_b_1), .pc_0(d3_pc_0), .pc_1(d3_pc_1),
        .gnt_0(d3_gnt_0), .gnt_1(d3_gnt_1), .rsp_valid_0(d3_rsp_valid_0), .rsp_valid_1(d3_rsp_valid_1),
        .rsp_data(d3_rsp_data), .rsp_zero(d3_rsp_zero), .rsp_err(d3_rsp_err), .busy(d3_busy),
        .alu_data_1(d3_alu_data_1), .alu_data_2(d3_alu_data_2), .alu_op(d3_alu_op), .alu_pc(d3_alu_pc),
        .alu_data_out(d3_alu_data_out), .alu_zero(d3_alu_zero)
`ifdef ALU_SHARE_PERF_EN
        , .gnt_cnt_0(d3_gnt_cnt_0), .gnt_cnt_1(d3_gnt_cnt_1), .stall_cnt(d3_stall_cnt)
`endif
    );

    // ---------------- behavioural ALU models ----------------
    function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [5:0] pc);
        case (op)
            6'd0:    alu_f = a + b;
            6'd1:    alu_f = a - b;
            6'd19:   alu_f = {26'd0, pc} + (b << 12);
            default: alu_f = a + b;
        endcase
    endfunction

    logic [31:0] m1_data;
    logic        m1_zero;
    always @(posedge clock) begin
        m1_data <= alu_f(alu_op, alu_data_1, alu_data_2, alu_pc);
        m1_zero <= (alu_data_1 == alu_data_2);
    end
    assign alu_data_out = m1_data;
    assign alu_zero     = m1_zero;

    logic [31:0] m3_data [3];
    logic        m3_zero [3];
    always @(posedge clock) begin
        m3_data[0] <= alu_f(d3_alu_op, d3_alu_data_1, d3_alu_data_2, d3_alu_pc);
        m3_zero[0] <= (d3_alu_data_1 == d3_alu_data_2);
        m3_data[1] <= m3_data[0];
        m3_zero[1] <= m3_zero[0];
        m3_data[2] <= m3_data[1];
        m3_zero[2] <= m3_zero[1];
    end
    assign d3_alu_data_out = m3_data[2];
    assign d3_alu_zero     = m3_zero[2];

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          port;
        logic [31:0] data;
        bit          zero;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    bit   gnt_log[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   d3_rsp_seen = 0;
    bit   chk_op0 = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor for the main instance
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            check("gnt_exclusive", 32'(gnt_0 & gnt_1), 32'(0));
            check("rsp_exclusive", 32'(rsp_valid_0 & rsp_valid_1), 32'(0));
            if (gnt_0) gnt_log.push_back(1'b0);
            else if (gnt_1) gnt_log.push_back(1'b1);
            if (chk_op0) check("alu_idle_on_err", 32'({alu_op, alu_pc, alu_data_1, alu_data_2} == '0), 32'(1));
            if (rsp_valid_0 || rsp_valid_1) begin
                check("rsp_expected", 32'(q1.size() != 0), 32'(1));
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    check("rsp_owner", 32'(rsp_valid_1), 32'(e.port));
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // Monitor for the ALU_LATENCY=3 instance
    always @(negedge clock) begin
        exp_t e;
        if (!reset3) begin
            if (d3_rsp_valid_0 || d3_rsp_valid_1) begin
                d3_rsp_seen <= d3_rsp_seen + 1;
                check("d3_rsp_expected", 32'(q3.size() != 0), 32'(1));
                if (q3.size() != 0) begin
                    e = q3.pop_front();
                    check("d3_rsp_owner", 32'(d3_rsp_valid_1), 32'(e.port));
                    check("d3_rsp_data", d3_rsp_data, e.data);
                    check("d3_rsp_zero", 32'(d3_rsp_zero), 32'(e.zero));
                    check("d3_rsp_err", 32'(d3_rsp_err), 32'(e.err));
                    check("d3_rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_rst(input bit dut);
        if (!dut) begin
            check("rst_flags", 32'({gnt_0, gnt_1, rsp_valid_0, rsp_valid_1, rsp_zero, rsp_err, busy}), 32'(0));
            check("rst_rsp_data", rsp_data, 32'(0));
            check("rst_alu", 32'({alu_op, alu_pc, alu_data_1, alu_data_2} == '0), 32'(1));
        end else begin
            check("d3_rst_flags", 32'({d3_gnt_0, d3_gnt_1, d3_rsp_valid_0, d3_rsp_valid_1,
                                       d3_rsp_zero, d3_rsp_err, d3_busy}), 32'(0));
            check("d3_rst_rsp_data", d3_rsp_data, 32'(0));
            check("d3_rst_alu", 32'({d3_alu_op, d3_alu_pc, d3_alu_data_1, d3_alu_data_2} == '0), 32'(1));
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check_rst(1'b0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Raise a request, wait for its grant, queue the expected response
    task automatic request(input bit dut, input bit port, input logic [5:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [5:0] pc,
                           input logic [31:0] ed, input bit ez, input bit ee,
                           input int gdelay, input bit keep);
        int   r;
        int   g;
        bit   got;
        exp_t e;
        if (dut) begin
            d3_op_1 = op; d3_a_1 = a; d3_b_1 = b; d3_pc_1 = pc; d3_req_1 = 1'b1;
        end else if (port) begin
            op_1 = op; a_1 = a; b_1 = b; pc_1 = pc; req_1 = 1'b1;
        end else begin
            op_0 = op; a_0 = a; b_0 = b; pc_0 = pc; req_0 = 1'b1;
        end
        r   = cyc;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clock);
            if (dut) got = d3_gnt_1;
            else     got = port ? gnt_1 : gnt_0;
        end
        check("gnt_seen", 32'(got), 32'(1));
        if (got) begin
            g      = cyc;
            e.port = dut ? 1'b1 : port;
            e.data = ed;
            e.zero = ez;
            e.err  = ee;
            e.cyc  = g + (ee ? 1 : ((dut ? 3 : 1) + 2));
            if (dut) q3.push_back(e);
            else     q1.push_back(e);
            if (gdelay >= 0) check("gnt_latency", 32'(g - r), 32'(gdelay));
        end
        @(posedge clock); #1;
        if (!keep) begin
            if (dut)       d3_req_1 = 1'b0;
            else if (port) req_1 = 1'b0;
            else           req_0 = 1'b0;
        end
    endtask

    task automatic wait_idle(input bit dut);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clock);
            done = dut ? (q3.size() == 0 && !d3_busy) : (q1.size() == 0 && !busy);
        end
        check("drain", 32'(done), 32'(1));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int  start;
        int  seen;
        bit  got;

        reset = 1'b1; reset3 = 1'b1;
        req_0 = 0; req_1 = 0; op_0 = 0; op_1 = 0; a_0 = 0; a_1 = 0; b_0 = 0; b_1 = 0; pc_0 = 0; pc_1 = 0;
        d3_req_0 = 0; d3_req_1 = 0; d3_op_0 = 0; d3_op_1 = 0; d3_a_0 = 0; d3_a_1 = 0;
        d3_b_0 = 0; d3_b_1 = 0; d3_pc_0 = 0; d3_pc_1 = 0;

        repeat (2) @(negedge clock);
        check_rst(1'b0);
        check_rst(1'b1);
        @(posedge clock); #1;
        reset = 1'b0; reset3 = 1'b0;

        // Single ADD: 5 + 7 = 12
        request(0, 0, 6'd0, 32'd5, 32'd7, 6'd0, 32'd12, 0, 0, 1, 0);
        wait_idle(0);
        check("rsp_data_hold", rsp_data, 32'd12);

        // Both request SUB 9-9 together from reset: 0 wins first, then 1
        do_reset();
        start = gnt_log.size();
        fork
            request(0, 0, 6'd1, 32'd9, 32'd9, 6'd0, 32'd0, 1, 0, 1, 0);
            request(0, 1, 6'd1, 32'd9, 32'd9, 6'd0, 32'd0, 1, 0, -1, 0);
        join
        wait_idle(0);
        check("pair_gnt_count", 32'(gnt_log.size() - start), 32'd2);
        if (gnt_log.size() >= start + 2) begin
            check("pair_first", 32'(gnt_log[start]), 32'd0);
            check("pair_second", 32'(gnt_log[start + 1]), 32'd1);
        end

        // Illegal opcode on requester 1: err response next cycle, ALU untouched
        chk_op0 = 1'b1;
        request(0, 1, 6'd25, 32'd33, 32'd44, 6'd3, 32'd0, 0, 1, 1, 0);
        wait_idle(0);
        chk_op0 = 1'b0;

        // Reset during WAIT on the latency-3 instance, then AUIPC
        d3_op_1 = 6'd0; d3_a_1 = 32'd1; d3_b_1 = 32'd2; d3_pc_1 = 6'd0; d3_req_1 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            got = d3_gnt_1;
        end
        check("d3_gnt_inflight", 32'(got), 32'(1));
        @(posedge clock); #1;
        d3_req_1 = 1'b0;
        @(posedge clock); #1;
        check("d3_busy_in_wait", 32'(d3_busy), 32'(1));
        seen   = d3_rsp_seen;
        reset3 = 1'b1;
        #1;
        check_rst(1'b1);
        repeat (2) @(posedge clock);
        #1 reset3 = 1'b0;
        repeat (8) @(negedge clock);
        check("d3_no_rsp_after_reset", 32'(d3_rsp_seen - seen), 32'(0));
        request(1, 1, 6'd19, 32'd0, 32'd1, 6'd4, 32'd4100, 0, 0, 1, 0);
        wait_idle(1);

        // Both held for eight ops: strict alternation
        do_reset();
        start = gnt_log.size();
        fork
            begin
                request(0, 0, 6'd0, 32'd1,         32'd2,  6'd0, 32'd3,   0, 0, -1, 1);
                request(0, 0, 6'd0, 32'd100,       32'd23, 6'd0, 32'd123, 0, 0, -1, 1);
                request(0, 0, 6'd0, 32'd7,         32'd7,  6'd0, 32'd14,  1, 0, -1, 1);
                request(0, 0, 6'd0, 32'hFFFF_FFFF, 32'd1,  6'd0, 32'd0,   0, 0, -1, 0);
            end
            begin
                request(0, 1, 6'd1,  32'd10, 32'd3,  6'd0, 32'd7,          0, 0, -1, 1);
                request(0, 1, 6'd1,  32'd3,  32'd10, 6'd0, 32'hFFFF_FFF9,  0, 0, -1, 1);
                request(0, 1, 6'd1,  32'd5,  32'd5,  6'd0, 32'd0,          1, 0, -1, 1);
                request(0, 1, 6'd19, 32'd0,  32'd2,  6'd1, 32'd8193,       0, 0, -1, 0);
            end
        join
        wait_idle(0);
        check("rr_gnt_count", 32'(gnt_log.size() - start), 32'd8);
        if (gnt_log.size() >= start + 8) begin
            for (int i = 0; i < 8; i++) begin
                check("rr_order", 32'(gnt_log[start + i]), 32'(i % 2));
            end
        end
`ifdef ALU_SHARE_PERF_EN
        check("perf_gnt_cnt_0", 32'(gnt_cnt_0), 32'd4);
        check("perf_gnt_cnt_1", 32'(gnt_cnt_1), 32'd4);
        check("perf_stall_nonzero", 32'(stall_cnt != 16'd0), 32'd1);
`endif

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
